// File: rtl/spi_slave_core.sv
// SPI slave core: synchronizes the SPI pins into i_Clk, supports all four CPOL/CPHA modes,
// and exchanges bytes MSB first through an RX byte register and a single-entry TX buffer.
module spi_slave_core #(
  parameter int unsigned SYNC_STAGES = 2  // 2 or 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_CPOL,
  input  logic       i_CPHA,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } state_e;

  // Pin synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   cs_prev_q;

  logic sck_s;
  logic cs_s;
  logic mosi_s;

  // Transfer state
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_dv_q, rx_dv_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;

  // Decoded events
  logic sck_changed;
  logic lead_edge;
  logic trail_edge;
  logic active;
  logic sample_edge;
  logic shift_edge;
  logic cs_fall;
  logic cs_rise;
  logic byte_start;
  logic tx_accept;
  logic [7:0] rx_next;

  // Synchronizers reset to the idle level of each pin so no false edge appears after reset.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sck_sync_q  <= {SYNC_STAGES{i_CPOL}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sck_prev_q  <= i_CPOL;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_comb begin
    sck_changed = sck_s ^ sck_prev_q;
    lead_edge   = sck_changed & (sck_s != i_CPOL);
    trail_edge  = sck_changed & (sck_s == i_CPOL);
    cs_fall     = cs_prev_q & ~cs_s;
    cs_rise     = ~cs_prev_q & cs_s;
    // The cycle that sees CS_n rise is already deselected, so edges there are dropped.
    active      = (state_q == StActive) & ~cs_s;
    sample_edge = active & (i_CPHA ? trail_edge : lead_edge);
    shift_edge  = active & (i_CPHA ? lead_edge : trail_edge);
    byte_start  = (cs_fall & ~i_CPHA) | (shift_edge & (bit_cnt_q == 3'd0));
    tx_accept   = i_TX_DV & ~tx_full_q;
    rx_next     = {rx_shift_q[6:0], mosi_s};
  end

  // Chip-select state machine
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cs_fall) state_d = StActive;
      StActive: if (cs_rise) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Receive path
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    if (cs_fall || cs_rise) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
    end else if (sample_edge) begin
      rx_shift_d = rx_next;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_byte_d = rx_next;
        rx_dv_d   = 1'b1;
      end
    end
  end

  // Transmit path: holding buffer feeds the shift register at every byte start.
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    if (byte_start) begin
      if (tx_accept) begin
        // A strobe landing on the load cycle bypasses the buffer.
        tx_shift_d = i_TX_Byte;
      end else if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = 8'h00;
      end
    end else begin
      if (shift_edge) begin
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
      if (tx_accept) begin
        tx_buf_d  = i_TX_Byte;
        tx_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
      tx_shift_q <= 8'h00;
      tx_buf_q   <= 8'h00;
      tx_full_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
    end
  end

  // MISO is the top of the shift register, so it simply holds while deselected.
  assign o_SPI_MISO    = tx_shift_q[7];
  assign o_SPI_MISO_En = ~cs_s;
  assign o_TX_Ready    = ~tx_full_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Byte     = rx_byte_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a behavioural SPI master plus a byte-slot model of the TX buffer;
// expected RX bytes go to a queue that a monitor drains on every o_RX_DV pulse.
module tb_spi_slave_core;

  localparam int unsigned SYNC = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_dv = 1'b0;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       tx_ready;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       miso;
  logic       miso_en;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  time        edge_t = 0;

  // Model of the single-entry TX holding buffer
  bit         buf_valid = 1'b0;
  logic [7:0] buf_val = 8'h00;

  spi_slave_core #(
    .SYNC_STAGES(SYNC)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_CPOL       (cpol),
    .i_CPHA       (cpha),
    .i_TX_Byte    (tx_byte),
    .i_TX_DV      (tx_dv),
    .o_TX_Ready   (tx_ready),
    .o_RX_DV      (rx_dv),
    .o_RX_Byte    (rx_byte),
    .i_SPI_Clk    (sck),
    .i_SPI_CS_n   (cs_n),
    .i_SPI_MOSI   (mosi),
    .o_SPI_MISO   (miso),
    .o_SPI_MISO_En(miso_en)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h expected=%02h", name, got, exp);
    end
  endtask

  // RX monitor: every o_RX_DV cycle must match the next expected byte within the latency bound.
  always @(negedge clk) begin
    if (rx_dv !== 1'b0) begin
      checks++;
      if (rx_exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_dv_spurious got=%02h expected=no_pulse", rx_byte);
      end else begin
        logic [7:0] exp;
        exp = rx_exp_q.pop_front();
        if (rx_byte !== exp) begin
          errors++;
          $display("FAIL rx_byte got=%02h expected=%02h", rx_byte, exp);
        end
      end
      checks++;
      if ($time - 5 - edge_t > (SYNC + 2) * 10) begin
        errors++;
        $display("FAIL rx_latency got=%0t expected<=%0d", $time - 5 - edge_t, (SYNC + 2) * 10);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A byte start consumes whatever the buffer holds, or zero when empty.
  task automatic take_slot();
    tx_exp_q.push_back(buf_valid ? buf_val : 8'h00);
    buf_valid = 1'b0;
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_byte = b;
    tx_dv   = 1'b1;
    if (!buf_valid) begin
      buf_val   = b;
      buf_valid = 1'b1;
    end
    @(negedge clk);
    tx_dv = 1'b0;
  endtask

  task automatic wait_ready();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (tx_ready === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tx_ready_wait got=timeout expected=ready");
    end
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sck  = p;
    tick(4);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    if (!cpha) take_slot();
  endtask

  task automatic cs_high();
    tick(HALF);
    cs_n = 1'b1;
    tx_exp_q.delete();
    tick(2 * HALF);
  endtask

  task automatic xfer_byte(input logic [7:0] b, input int nbits);
    logic [7:0] got;
    logic [7:0] exp;
    got = 8'h00;
    if (cpha) take_slot();
    if (nbits == 8) rx_exp_q.push_back(b);
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = b[i];
        tick(HALF);
        got[i] = miso;
        sck    = ~cpol;
        edge_t = $time;
        tick(HALF);
        sck = cpol;
      end else begin
        tick(HALF);
        sck  = ~cpol;
        mosi = b[i];
        tick(HALF);
        got[i] = miso;
        sck    = cpol;
        edge_t = $time;
      end
    end
    exp = (tx_exp_q.size() != 0) ? tx_exp_q.pop_front() : 8'hxx;
    if (nbits == 8) begin
      check8("miso_byte", got, exp);
      check8("miso_en", {7'd0, miso_en}, 8'h01);
      if (!cpha) take_slot();
    end
  endtask

  initial begin
    int         nb;
    int         nbits;
    logic [7:0] b;

    tick(3);
    check8("rst_tx_ready", {7'd0, tx_ready}, 8'h01);
    check8("rst_rx_dv", {7'd0, rx_dv}, 8'h00);
    check8("rst_rx_byte", rx_byte, 8'h00);
    check8("rst_miso", {7'd0, miso}, 8'h00);
    check8("rst_miso_en", {7'd0, miso_en}, 8'h00);
    rst = 1'b0;
    tick(4);

    // Mode 0, preloaded A5, master sends 3C
    set_mode(1'b0, 1'b0);
    load_tx(8'hA5);
    check8("ready_after_load", {7'd0, tx_ready}, 8'h00);
    cs_low();
    xfer_byte(8'h3C, 8);
    cs_high();
    check8("rx_hold_3c", rx_byte, 8'h3C);

    // Mode 3
    set_mode(1'b1, 1'b1);
    load_tx(8'h81);
    cs_low();
    xfer_byte(8'h7E, 8);
    cs_high();
    check8("rx_hold_7e", rx_byte, 8'h7E);

    // Mode 1 burst, second byte loaded once the first is taken
    set_mode(1'b0, 1'b1);
    load_tx(8'h12);
    cs_low();
    fork
      begin
        xfer_byte(8'hDE, 8);
        xfer_byte(8'hAD, 8);
      end
      begin
        wait_ready();
        load_tx(8'h34);
      end
    join
    cs_high();

    // Mode 2, nothing loaded
    set_mode(1'b1, 1'b0);
    cs_low();
    xfer_byte(8'hFF, 8);
    cs_high();
    check8("rx_hold_ff", rx_byte, 8'hFF);

    // Mode 0 abort after 4 bits; buffered 5A must survive, junk strobe while full is ignored
    set_mode(1'b0, 1'b0);
    load_tx(8'hC3);
    cs_low();
    wait_ready();
    load_tx(8'h5A);
    load_tx(8'hEE);
    xfer_byte(8'h0F, 4);
    cs_high();
    check8("abort_buf_kept", {7'd0, tx_ready}, {7'd0, ~buf_valid});
    cs_low();
    xfer_byte(8'h55, 8);
    cs_high();
    check8("rx_hold_55", rx_byte, 8'h55);

    // Reset pulsed after 5 bits
    load_tx(8'hFF);
    cs_low();
    xfer_byte(8'hB7, 5);
    rst = 1'b1;
    buf_valid = 1'b0;
    #2;
    check8("midrst_rx_byte", rx_byte, 8'h00);
    check8("midrst_rx_dv", {7'd0, rx_dv}, 8'h00);
    check8("midrst_miso", {7'd0, miso}, 8'h00);
    check8("midrst_miso_en", {7'd0, miso_en}, 8'h00);
    check8("midrst_tx_ready", {7'd0, tx_ready}, 8'h01);
    tick(2);
    rst = 1'b0;
    tick(2);
    cs_high();
    set_mode(1'b1, 1'b0);
    load_tx(8'h6D);
    cs_low();
    xfer_byte(8'h92, 8);
    cs_high();

    // Randomized sessions
    for (int s = 0; s < 24; s++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        load_tx(8'($urandom));
        if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
      end
      check8("rand_ready", {7'd0, tx_ready}, {7'd0, ~buf_valid});
      nb = $urandom_range(1, 3);
      cs_low();
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        nbits = 8;
        if (k == nb - 1 && $urandom_range(0, 5) == 0) nbits = $urandom_range(1, 7);
        xfer_byte(b, nbits);
      end
      cs_high();
    end

    tick(20);
    check8("rx_pending", 8'(rx_exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SYNC_STAGES, default 2: number of flip-flop stages on each of i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI; legal values 2 and 3.
REQ-002 i_Clk  in  1  system clock; every register in the block SHALL be clocked on its rising edge.
REQ-003 i_Rst  in  1  reset, asynchronous, active-high.
REQ-004 i_CPOL  in  1  SPI clock idle level; SHALL only change while i_SPI_CS_n=1.
REQ-005 i_CPHA  in  1  SPI phase: 0 = sample on leading edge, 1 = sample on trailing edge; SHALL only change while i_SPI_CS_n=1.
REQ-006 i_TX_Byte  in  8  next byte to return to the master on MISO.
REQ-007 i_TX_DV  in  1  one-cycle strobe qualifying i_TX_Byte.
REQ-008 o_TX_Ready  out  1  TX holding buffer empty; the block accepts i_TX_DV.
REQ-009 o_RX_DV  out  1  one-cycle pulse; o_RX_Byte holds a new complete byte.
REQ-010 o_RX_Byte  out  8  last complete byte received from MOSI, MSB first.
REQ-011 i_SPI_Clk  in  1  SPI clock from the master, asynchronous to i_Clk.
REQ-012 i_SPI_CS_n  in  1  chip select from the master, active-low, asynchronous.
REQ-013 i_SPI_MOSI  in  1  serial data from the master.
REQ-014 o_SPI_MISO  out  1  serial data to the master, MSB first.
REQ-015 o_SPI_MISO_En  out  1  high while selected; top level uses it for the tri-state enable.

Function
REQ-016 Synchronizers: i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI SHALL pass through SYNC_STAGES flip-flops. Edges SHALL be detected by comparing the synchronized value with its value one cycle earlier.
REQ-017 Clock ratio: correct operation SHALL be guaranteed when each SPI clock half-period is at least 4 i_Clk cycles.
REQ-018 Edge definitions:
- leading edge = synchronized SCK leaves i_CPOL;
- trailing edge = synchronized SCK returns to i_CPOL;
- sample edge = leading edge if i_CPHA=0, else trailing edge;
- shift edge = the opposite edge.
SCK edges SHALL be ignored while synchronized CS_n=1.
REQ-019 State machine IDLE/ACTIVE:
- IDLE->ACTIVE on the synchronized CS_n falling edge;
- ACTIVE->IDLE on the synchronized CS_n rising edge;
- reset state is IDLE.
REQ-020 RX: on each sample edge in ACTIVE, shift synchronized MOSI into the RX shift register and increment a 3-bit bit counter.
REQ-021 RX completion: when the 8th bit is sampled (counter wraps 7->0), o_RX_Byte SHALL update and o_RX_DV SHALL pulse for exactly one cycle. This SHALL occur no later than SYNC_STAGES+2 i_Clk cycles after that edge at the pin.
REQ-022 TX buffer: i_TX_DV while o_TX_Ready=1 SHALL load the buffer and deassert o_TX_Ready on the next cycle. i_TX_DV while o_TX_Ready=0 SHALL be ignored and SHALL leave the buffer unchanged.
REQ-023 TX byte load: at each byte start the TX shift register SHALL load the buffer contents, or 8'h00 if the buffer is empty.
- Byte starts: CS_n falling edge when i_CPHA=0; shift edges where the bit counter is 0 (including the first leading edge when i_CPHA=1).
- On a load, o_SPI_MISO = bit 7 and o_TX_Ready=1 on the following cycle.
REQ-024 TX shifting: every other shift edge in ACTIVE SHALL drive the next lower bit onto o_SPI_MISO.
REQ-025 Simultaneous events: if i_TX_DV and a byte-start load occur in the same cycle, i_TX_Byte SHALL be loaded directly into the TX shift register and the buffer SHALL remain empty.
REQ-026 Multi-byte: while CS_n stays low, consecutive bytes SHALL be transferred with no idle bits between them.
REQ-027 Abort: CS_n rising mid-byte SHALL:
- clear the bit counter;
- discard partial RX data with no o_RX_DV;
- preserve the TX buffer;
- discard the partially sent TX byte.
REQ-028 o_SPI_MISO_En SHALL equal the inverted synchronized CS_n. o_SPI_MISO SHALL hold its last value while in IDLE.

Reset
REQ-029 i_Rst=1 SHALL immediately force:
- o_RX_Byte=8'h00, o_RX_DV=0, o_SPI_MISO=0, o_SPI_MISO_En=0;
- o_TX_Ready=1, TX buffer empty, bit counter 0, state IDLE;
- synchronizer stages: SCK stages to i_CPOL, CS_n stages to 1, MOSI stages to 0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no o_RX_DV. After release, the block SHALL wait for a fresh CS_n falling edge before transferring.

Verification
REQ-031 Mode 0, TX 0xA5 preloaded, master sends 0x3C at 8 i_Clk per half-bit -> master receives 0xA5; o_RX_Byte=0x3C; one o_RX_DV pulse.
REQ-032 Mode 3, TX 0x81, master sends 0x7E -> master receives 0x81; o_RX_Byte=0x7E.
REQ-033 Mode 1, 2-byte burst, TX 0x12 then 0x34 loaded after the first o_TX_Ready rise, master sends 0xDE,0xAD -> MISO carries 0x12,0x34; two o_RX_DV pulses with 0xDE then 0xAD.
REQ-034 Mode 2, no TX loaded, master sends 0xFF -> MISO carries 0x00; o_RX_Byte=0xFF.
REQ-035 Mode 0, CS_n raised after 4 bits, then a full 0x55 transfer -> no o_RX_DV for the partial byte; o_RX_Byte=0x55.
REQ-036 i_Rst pulsed after 5 bits of a transfer -> all outputs at their reset values; no o_RX_DV; the next full transfer is correct.
